// File: rtl/multicycle_alu.sv
// multicycle_alu: registered XLEN-bit execute-stage ALU; single-cycle integer ops, iterative mul/div (macro MULTICYCLE_ALU_MULDIV_EN).
// Latency: 1 cycle for ops 0-9; XLEN+1 cycles for ops 10-15 when mul/div is built, otherwise 1 cycle flagged illegal.
// Backpressure: in_ready only in IDLE; result/flags held in DONE until out_ready; flush kills any in-flight op.
module multicycle_alu #(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            ltz,
  output logic            illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic            start;
  logic            is_md;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            load_res;
  logic [XLEN-1:0] res_val;
  logic            ill_val;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  // flush has priority over a simultaneous accept
  assign start     = in_valid && in_ready && !flush;
  // ops 10..15 are the mul/div group
  assign is_md     = op[3] & (op[2] | op[1]);
  assign shamt     = op2[SHW-1:0];

  // Single-cycle integer operations
  always_comb begin
    alu_res = '0;
    case (op)
      4'd0:    alu_res = op1 + op2;
      4'd1:    alu_res = op1 - op2;
      4'd2:    alu_res = op1 & op2;
      4'd3:    alu_res = op1 | op2;
      4'd4:    alu_res = op1 ^ op2;
      4'd5:    alu_res = op1 << shamt;
      4'd6:    alu_res = op1 >> shamt;
      4'd7:    alu_res = $signed(op1) >>> shamt;
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      default: alu_res = '0;
    endcase
  end

`ifdef MULTICYCLE_ALU_MULDIV_EN
  localparam int CW = $clog2(XLEN) + 1;

  // hi/lo: product halves for mul, partial remainder / quotient for div
  logic [XLEN-1:0] hi, lo, opb;
  logic [3:0]      op_q;
  logic            neg_q, neg_r;
  logic [CW-1:0]   cnt;

  logic            is_mul;
  logic [XLEN-1:0] mul_add;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_sub;
  logic            rem_ge;
  logic [XLEN-1:0] hi_nxt, lo_nxt;
  logic [XLEN-1:0] md_final;
  logic            div_sgn;
  logic            s1, s2;
  logic [XLEN-1:0] mag1, mag2;

  assign is_mul  = (op_q[3:1] == 3'b101);
  assign mul_add = lo[0] ? opb : '0;
  assign mul_sum = {1'b0, hi} + {1'b0, mul_add};
  assign rem_sh  = {hi, lo[XLEN-1]};
  assign rem_sub = rem_sh - {1'b0, opb};
  assign rem_ge  = (rem_sh >= {1'b0, opb});

  // Operand conditioning at accept: signed divides work on magnitudes
  assign div_sgn = ~op[0];
  assign s1      = div_sgn & op1[XLEN-1];
  assign s2      = div_sgn & op2[XLEN-1];
  assign mag1    = s1 ? (-op1) : op1;
  assign mag2    = s2 ? (-op2) : op2;

  // One shift-add or restoring-subtract step
  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    if (is_mul) begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
    end else begin
      hi_nxt = rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], rem_ge};
    end
  end

  // Final result selection from the last step; a zero divisor already yields an all-ones quotient
  always_comb begin
    md_final = '0;
    case (op_q)
      4'd10:   md_final = lo_nxt;
      4'd11:   md_final = hi_nxt;
      4'd12:   md_final = neg_q ? (-lo_nxt) : lo_nxt;
      4'd13:   md_final = lo_nxt;
      4'd14:   md_final = neg_r ? (-hi_nxt) : hi_nxt;
      4'd15:   md_final = hi_nxt;
      default: md_final = '0;
    endcase
  end

  // Iterative datapath registers and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
    end else if (start && is_md) begin
      op_q  <= op;
      hi    <= '0;
      cnt   <= CW'(XLEN);
      if (op[3:1] == 3'b101) begin
        lo  <= op1;
        opb <= op2;
      end else begin
        lo  <= mag1;
        opb <= mag2;
      end
      // quotient sign only flips for a nonzero divisor so divide-by-zero stays all ones
      neg_q <= (s1 ^ s2) && (op2 != '0);
      neg_r <= s1;
    end else if (state == BUSY) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt - CW'(1);
    end
  end
`endif

  // Next-state and result-load decode
  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    res_val   = '0;
    ill_val   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_md) begin
`ifdef MULTICYCLE_ALU_MULDIV_EN
            state_nxt = BUSY;
`else
            state_nxt = DONE;
            load_res  = 1'b1;
            res_val   = '0;
            ill_val   = 1'b1;
`endif
          end else begin
            state_nxt = DONE;
            load_res  = 1'b1;
            res_val   = alu_res;
          end
        end
      end
`ifdef MULTICYCLE_ALU_MULDIV_EN
      BUSY: begin
        if (cnt == CW'(1)) begin
          state_nxt = DONE;
          load_res  = 1'b1;
          res_val   = md_final;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      load_res  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result and flags register together on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      zero    <= 1'b0;
      ltz     <= 1'b0;
      illegal <= 1'b0;
    end else if (load_res) begin
      result  <= res_val;
      zero    <= (res_val == '0);
      ltz     <= res_val[XLEN-1];
      illegal <= ill_val;
    end
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered execute-stage ALU for the RISC-V pipeline: single-cycle integer ops plus iterative multiply/divide behind a valid/ready handshake. Generalises the combinational 64-bit ALU to `XLEN` width, a 16-entry op set, signed/unsigned compares and flag outputs. It sits between ID/EX operand latch and EX/MEM; the pipeline stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, 64: operand/result width (power of two, ≥8)
- `SHW`, $clog2(XLEN): shift-amount width (derived, do not override)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous kill of any in-flight op
- `in_valid`  in  1  operands/op presented
- `in_ready`  out  1  block can accept (high only in IDLE)
- `op`  in  4  operation code
- `op1`, `op2`  in  XLEN  operands
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer takes result
- `result`  out  XLEN  registered result
- `zero`  out  1  `result == 0`
- `ltz`  out  1  `result[XLEN-1]`
- `illegal`  out  1  op not supported in this build

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low XLEN), 11 MULHU (high XLEN, unsigned), 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- Shifts use `op2[SHW-1:0]` only; SRA sign-fills. SLT/SLTU return 1 or 0, zero-extended. ADD/SUB wrap modulo 2^XLEN.
- FSM states IDLE, BUSY, DONE. Accept = `in_valid && in_ready`.
  - IDLE + accept, ops 0–9: compute, register result, → DONE.
  - IDLE + accept, ops 10–15: latch operands, load counter = XLEN, → BUSY.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; counter decrements; at counter 1 → DONE with final result registered.
  - DONE: `out_valid`=1; result/flags stable; on `out_ready` → IDLE.
- Multiply: unsigned 2·XLEN-bit product; MUL returns low half, MULHU high half.
- Divide: operates on magnitudes; quotient negated when signs differ (DIV), remainder takes dividend sign (REM).
- Divide by zero: quotient = all ones, remainder = op1. Signed overflow (MIN / −1): quotient = MIN, remainder = 0. Both still take full XLEN iterations (fixed latency).
- `zero`/`ltz` registered together with `result`.

## Timing
- Reset: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `zero`=0, `ltz`=0, `illegal`=0, counter 0.
- `in_ready` is combinational from state (`state==IDLE`); no accept in DONE, even with `out_ready` high.
- Latency accept→`out_valid`: 1 cycle for ops 0–9, XLEN+1 cycles for ops 10–15.
- Throughput: one op per (latency + 1) cycles minimum when `out_ready` held high.
- `out_valid` held with stable outputs until `out_ready`; backpressure of any length allowed.
- `flush`: next edge → IDLE, `out_valid`=0, result discarded; `flush` with `in_valid` in IDLE drops the op (flush wins).
- Async reset mid-BUSY: immediate abort to reset values; no partial result appears.

## Configuration
- `MULTICYCLE_ALU_MULDIV_EN` defined: ops 10–15 implemented as above; `illegal` always 0.
- Not defined: no multiplier/divider datapath or counter built; ops 10–15 complete in 1 cycle with `result`=0, `zero`=1, `ltz`=0, `illegal`=1; ops 0–9 unchanged.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → all outputs at reset values, `in_ready`=1 same cycle.
- ADD 0xFFFF_FFFF_FFFF_FFFF + 1 → `result`=0, `zero`=1, `out_valid` 1 cycle after accept; SRA 0x8000_0000_0000_0000 by 0x43 (uses 3) → 0xF000_0000_0000_0000, `ltz`=1.
- SLT −1 vs 1 → 1; SLTU −1 vs 1 → 0.
- MUL 0xFFFF_FFFF × 2 → 0x1_FFFF_FFFE; MULHU 2^63 × 4 → 2; `out_valid` exactly 65 cycles after accept, `in_ready`=0 throughout.
- DIVU 100 / 0 → all ones; REM −7 / 2 → −1; DIV 0x8000…0 / −1 → 0x8000…0; hold `out_ready`=0 for 10 cycles → result stable, then IDLE one cycle after handshake.
- `flush` at BUSY cycle 20 → IDLE next edge, no `out_valid`; without macro, op 12 → `illegal`=1, `result`=0 after 1 cycle.
